// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin core/debug access to a 32-bit byte-write data RAM.
// Define DMEM_ALIGN_CHECK_EN to trap misaligned core accesses instead of forcing alignment.
module dmem_ctrl #(
    parameter int unsigned RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    input  logic [31:0]       core_addr,
    input  logic [63:0]       core_wdata,
    output logic              core_ack,
    output logic              core_err,
    output logic [63:0]       core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int unsigned AHI = RAM_AW + 1;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, B0, B1, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic              last_dbg_q, last_dbg_d;
    logic              gnt_dbg_q, gnt_dbg_d;
    logic              lat_we_q, lat_we_d;
    logic [1:0]        lat_size_q, lat_size_d;
    logic              lat_uns_q, lat_uns_d;
    logic [1:0]        lat_off_q, lat_off_d;
    logic [RAM_AW-1:0] lat_waddr_q, lat_waddr_d;
    logic [31:0]       lat_whi_q, lat_whi_d;
    logic [31:0]       lo_word_q, lo_word_d;
    logic [RAM_AW-1:0] ram_addr_d;
    logic [3:0]        ram_we_d;
    logic [31:0]       ram_wdata_d;
    logic              core_ack_d, core_err_d, dbg_ack_d;

    logic [2:0]        core_amask;
    logic              core_mis;
    logic [AHI:0]      core_eff;
    logic              core_win;
    logic [3:0]        st_we;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_shift;
    logic [63:0]       ld_data;
    logic              unused_addr;

    assign unused_addr = ^{core_addr[31:AHI+1], dbg_addr[31:AHI+1], dbg_addr[1:0]};

    // Natural-alignment mask per access size; either trap or clear the low bits.
    always_comb begin
        case (core_size)
            SZ_BYTE: core_amask = 3'b000;
            SZ_HALF: core_amask = 3'b001;
            SZ_WORD: core_amask = 3'b011;
            default: core_amask = 3'b111;
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        core_mis = |(core_addr[2:0] & core_amask);
        core_eff = core_addr[AHI:0];
`else
        core_mis = 1'b0;
        core_eff = {core_addr[AHI:3], core_addr[2:0] & ~core_amask};
`endif
    end

    // Store lane enables and replicated write data for the first beat.
    always_comb begin
        case (core_size)
            SZ_BYTE: begin
                st_we    = 4'b0001 << core_eff[1:0];
                st_wdata = {4{core_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_we    = 4'b0011 << core_eff[1:0];
                st_wdata = {2{core_wdata[15:0]}};
            end
            default: begin
                st_we    = 4'b1111;
                st_wdata = core_wdata[31:0];
            end
        endcase
    end

    assign core_win = core_req && (!dbg_req || last_dbg_q);

    always_comb begin
        state_d     = state_q;
        last_dbg_d  = last_dbg_q;
        gnt_dbg_d   = gnt_dbg_q;
        lat_we_d    = lat_we_q;
        lat_size_d  = lat_size_q;
        lat_uns_d   = lat_uns_q;
        lat_off_d   = lat_off_q;
        lat_waddr_d = lat_waddr_q;
        lat_whi_d   = lat_whi_q;
        lo_word_d   = lo_word_q;
        ram_addr_d  = ram_addr;
        ram_we_d    = 4'b0000;
        ram_wdata_d = ram_wdata;
        core_ack_d  = 1'b0;
        core_err_d  = 1'b0;
        dbg_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_win) begin
                    gnt_dbg_d   = 1'b0;
                    last_dbg_d  = 1'b0;
                    lat_we_d    = core_we;
                    lat_size_d  = core_size;
                    lat_uns_d   = core_unsigned;
                    lat_off_d   = core_eff[1:0];
                    lat_waddr_d = core_eff[AHI:2];
                    lat_whi_d   = core_wdata[63:32];
                    if (core_mis) begin
                        state_d    = ERR;
                        core_ack_d = 1'b1;
                        core_err_d = 1'b1;
                    end else begin
                        state_d     = B0;
                        ram_addr_d  = core_eff[AHI:2];
                        ram_we_d    = core_we ? st_we : 4'b0000;
                        ram_wdata_d = st_wdata;
                    end
                end else if (dbg_req) begin
                    gnt_dbg_d   = 1'b1;
                    last_dbg_d  = 1'b1;
                    lat_we_d    = dbg_we;
                    lat_size_d  = SZ_WORD;
                    lat_uns_d   = 1'b0;
                    lat_off_d   = 2'b00;
                    lat_waddr_d = dbg_addr[AHI:2];
                    state_d     = B0;
                    ram_addr_d  = dbg_addr[AHI:2];
                    ram_we_d    = dbg_we ? 4'b1111 : 4'b0000;
                    ram_wdata_d = dbg_wdata;
                end
            end
            B0: begin
                if (!gnt_dbg_q && lat_size_q == 2'b11) begin
                    state_d     = B1;
                    ram_addr_d  = RAM_AW'(lat_waddr_q + RAM_AW'(1));
                    ram_we_d    = lat_we_q ? 4'b1111 : 4'b0000;
                    ram_wdata_d = lat_whi_q;
                end else begin
                    state_d    = RESP;
                    core_ack_d = !gnt_dbg_q;
                    dbg_ack_d  = gnt_dbg_q;
                end
            end
            B1: begin
                lo_word_d  = ram_rdata;
                state_d    = RESP;
                core_ack_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_dbg_q  <= 1'b1;
            gnt_dbg_q   <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_uns_q   <= 1'b0;
            lat_off_q   <= 2'b00;
            lat_waddr_q <= '0;
            lat_whi_q   <= 32'd0;
            lo_word_q   <= 32'd0;
            ram_addr    <= '0;
            ram_we      <= 4'b0000;
            ram_wdata   <= 32'd0;
            core_ack    <= 1'b0;
            core_err    <= 1'b0;
            dbg_ack     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dbg_q  <= last_dbg_d;
            gnt_dbg_q   <= gnt_dbg_d;
            lat_we_q    <= lat_we_d;
            lat_size_q  <= lat_size_d;
            lat_uns_q   <= lat_uns_d;
            lat_off_q   <= lat_off_d;
            lat_waddr_q <= lat_waddr_d;
            lat_whi_q   <= lat_whi_d;
            lo_word_q   <= lo_word_d;
            ram_addr    <= ram_addr_d;
            ram_we      <= ram_we_d;
            ram_wdata   <= ram_wdata_d;
            core_ack    <= core_ack_d;
            core_err    <= core_err_d;
            dbg_ack     <= dbg_ack_d;
        end
    end

    // Load lane extraction; RAM data is only valid in RESP so rdata is formed there.
    always_comb begin
        ld_shift = ram_rdata >> {lat_off_q, 3'b000};
        case (lat_size_q)
            SZ_BYTE: ld_data = lat_uns_q ? {56'd0, ld_shift[7:0]}
                                         : {{56{ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data = lat_uns_q ? {48'd0, ld_shift[15:0]}
                                         : {{48{ld_shift[15]}}, ld_shift[15:0]};
            SZ_WORD: ld_data = lat_uns_q ? {32'd0, ram_rdata}
                                         : {{32{ram_rdata[31]}}, ram_rdata};
            default: ld_data = {ram_rdata, lo_word_q};
        endcase
    end

    assign core_rdata = (state_q == RESP && !gnt_dbg_q && !lat_we_q) ? ld_data : 64'd0;
    assign dbg_rdata  = (state_q == RESP && gnt_dbg_q && !lat_we_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: byte-array reference memory and transaction-level latency/arbitration model
// checked against dmem_ctrl driving a registered 32-bit RAM.
module tb_dmem_ctrl;
    localparam int unsigned RAM_AW = 12;
    localparam int DEPTH = 1 << RAM_AW;
    localparam int MEMB  = 4 * DEPTH;

    typedef struct {
        int          cyc;
        logic [63:0] rd;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_req = 1'b0, core_we = 1'b0, core_unsigned = 1'b0;
    logic [1:0]        core_size = 2'b00;
    logic [31:0]       core_addr = 32'd0;
    logic [63:0]       core_wdata = 64'd0;
    logic              core_ack, core_err;
    logic [63:0]       core_rdata;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0]       dbg_addr = 32'd0, dbg_wdata = 32'd0;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;

    logic [31:0] ram [DEPTH];
    logic [7:0]  ref_mem [MEMB];
    exp_t        qc[$], qd[$];
    int          cyc = 0;
    int          checks = 0, fails = 0;
    bit          chk_en = 1'b0;
    bit          m_last_dbg = 1'b1;
    int          x_start;
    logic [63:0] last_c_rd;
    logic        last_c_err;
    int          last_c_cyc;
    logic [31:0] last_d_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Registered-read byte-write RAM.
    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr];
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) ram[ram_addr][8*i +: 8] = ram_wdata[8*i +: 8];
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_core(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [63:0] wd,
                              output int lat, output logic [63:0] rd, output logic err);
        int nb, base;
        logic [63:0] v;
        nb = 1 << sz;
        rd = 64'd0; err = 1'b0; v = 64'd0;
        base = int'(addr) & (MEMB - 1);
        if ((base % nb) != 0) begin
`ifdef DMEM_ALIGN_CHECK_EN
            err = 1'b1;
            lat = 1;
            return;
`else
            base = base - (base % nb);
`endif
        end
        lat = (nb == 8) ? 3 : 2;
        for (int i = 0; i < nb; i++) begin
            if (we) ref_mem[(base + i) % MEMB] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[(base + i) % MEMB];
        end
        if (!we) begin
            if (!uns && nb < 8 && v[8*nb-1])
                for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
            rd = v;
        end
    endtask

    task automatic model_dbg(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd);
        int base;
        base = (int'(addr) & (MEMB - 1)) & ~3;
        rd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (we) ref_mem[base + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = ref_mem[base + i];
        end
    endtask

    // Predict grant order and ack cycles, then raise the requests at a falling edge.
    task automatic start_xact(input bit c_en, input bit d_en,
                              input logic cwe, input logic [1:0] csz, input logic cuns,
                              input logic [31:0] caddr, input logic [63:0] cwd,
                              input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd);
        int lat, t;
        logic [63:0] rd;
        logic err;
        logic [31:0] drd;
        exp_t e;
        bit core_first;
        @(negedge clk);
        x_start = cyc;
        t = cyc;
        core_first = c_en && (!d_en || m_last_dbg);
        for (int pass = 0; pass < 2; pass++) begin
            if ((pass == 0) == core_first) begin
                if (c_en) begin
                    model_core(cwe, csz, cuns, caddr, cwd, lat, rd, err);
                    e.cyc = t + lat; e.rd = rd; e.err = err;
                    qc.push_back(e);
                    t = e.cyc + 1;
                    m_last_dbg = 1'b0;
                end
            end else if (d_en) begin
                model_dbg(dwe, daddr, dwd, drd);
                e.cyc = t + 2; e.rd = {32'd0, drd}; e.err = 1'b0;
                qd.push_back(e);
                t = e.cyc + 1;
                m_last_dbg = 1'b1;
            end
        end
        core_we = cwe; core_size = csz; core_unsigned = cuns;
        core_addr = caddr; core_wdata = cwd;
        dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
        core_req = c_en; dbg_req = d_en;
    endtask

    // Hold each request until its ack, then drop it; bounded.
    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            if (core_req && core_ack) begin
                core_req = 1'b0; last_c_rd = core_rdata; last_c_err = core_err; last_c_cyc = cyc;
            end
            if (dbg_req && dbg_ack) begin
                dbg_req = 1'b0; last_d_rd = dbg_rdata;
            end
            if (!core_req && !dbg_req) break;
            @(negedge clk);
        end
        if (core_req || dbg_req) begin
            check_eq("xact_timeout", {62'd0, core_req, dbg_req}, 64'd0);
            core_req = 1'b0; dbg_req = 1'b0;
        end
    endtask

    task automatic core_op(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wd);
        start_xact(1'b1, 1'b0, we, sz, uns, addr, wd, 1'b0, 32'd0, 32'd0);
        wait_done();
    endtask

    // Per-cycle compare of ack/rdata/err against the predicted transactions.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && chk_en) begin
            if (core_ack) begin
                check_eq("core_ack_ram_we", 64'(ram_we), 64'd0);
                if (qc.size() == 0) check_eq("core_ack_unexpected", 64'(qc.size()), 64'd1);
                else begin
                    e = qc.pop_front();
                    check_eq("core_ack_cycle", 64'(cyc), 64'(e.cyc));
                    check_eq("core_rdata", core_rdata, e.rd);
                    check_eq("core_err", 64'(core_err), 64'(e.err));
                end
            end else begin
                check_eq("core_idle_rdata", core_rdata, 64'd0);
                check_eq("core_idle_err", 64'(core_err), 64'd0);
                if (qc.size() != 0 && qc[0].cyc <= cyc) begin
                    check_eq("core_ack_missing", 64'(core_ack), 64'd1);
                    void'(qc.pop_front());
                end
            end
            if (dbg_ack) begin
                check_eq("dbg_ack_ram_we", 64'(ram_we), 64'd0);
                if (qd.size() == 0) check_eq("dbg_ack_unexpected", 64'(qd.size()), 64'd1);
                else begin
                    e = qd.pop_front();
                    check_eq("dbg_ack_cycle", 64'(cyc), 64'(e.cyc));
                    check_eq("dbg_rdata", 64'(dbg_rdata), e.rd);
                end
            end else begin
                check_eq("dbg_idle_rdata", 64'(dbg_rdata), 64'd0);
                if (qd.size() != 0 && qd[0].cyc <= cyc) begin
                    check_eq("dbg_ack_missing", 64'(dbg_ack), 64'd1);
                    void'(qd.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, nc, nd, nbad;
        logic [3:0] ord;
        int nord;
        logic [31:0] w, old5, caddr, daddr;
        int lat;
        logic [63:0] rd;
        logic err;
        bit ce, de;

        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            ram[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_core_ack", 64'(core_ack), 64'd0);
        check_eq("rst_dbg_ack", 64'(dbg_ack), 64'd0);
        check_eq("rst_core_err", 64'(core_err), 64'd0);
        check_eq("rst_ram_we", 64'(ram_we), 64'd0);
        check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
        check_eq("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check_eq("rst_core_rdata", core_rdata, 64'd0);
        check_eq("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // SB 0xA5 to 0x103: first beat and latency.
        start_xact(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 64'hA5, 1'b0, 32'd0, 32'd0);
        n = x_start;
        @(negedge clk);
        check_eq("sb_ram_addr", 64'(ram_addr), 64'h040);
        check_eq("sb_ram_we", 64'(ram_we), 64'b1000);
        check_eq("sb_ram_wdata", 64'(ram_wdata), 64'hA5A5A5A5);
        wait_done();
        check_eq("sb_ack_latency", 64'(last_c_cyc - n), 64'd2);

        start_xact(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0, 1'b1, 32'h100, 32'h80123456);
        wait_done();
        core_op(1'b0, 2'b00, 1'b0, 32'h103, 64'd0);
        check_eq("lb_0x103", last_c_rd, 64'hFFFFFFFFFFFFFF80);
        core_op(1'b0, 2'b00, 1'b1, 32'h103, 64'd0);
        check_eq("lbu_0x103", last_c_rd, 64'h80);
        core_op(1'b0, 2'b01, 1'b0, 32'h102, 64'd0);
        check_eq("lh_0x102", last_c_rd, 64'hFFFFFFFFFFFF8012);
        start_xact(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0, 1'b0, 32'h103, 32'd0);
        wait_done();
        check_eq("dbg_rd_0x100", 64'(last_d_rd), 64'h80123456);

        // SD to 0x008: two beats, ack at N+3, then read back.
        start_xact(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h8, 64'h1122334455667788, 1'b0, 32'd0, 32'd0);
        n = x_start;
        @(negedge clk);
        check_eq("sd_b0_addr", 64'(ram_addr), 64'd2);
        check_eq("sd_b0_wdata", 64'(ram_wdata), 64'h55667788);
        check_eq("sd_b0_we", 64'(ram_we), 64'hF);
        @(negedge clk);
        check_eq("sd_b1_addr", 64'(ram_addr), 64'd3);
        check_eq("sd_b1_wdata", 64'(ram_wdata), 64'h11223344);
        check_eq("sd_b1_we", 64'(ram_we), 64'hF);
        wait_done();
        check_eq("sd_ack_latency", 64'(last_c_cyc - n), 64'd3);
        core_op(1'b0, 2'b11, 1'b0, 32'h8, 64'd0);
        check_eq("ld_0x008", last_c_rd, 64'h1122334455667788);

        // Both requesters held: grants alternate core, dbg, core, dbg.
        start_xact(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 64'd0, 1'b0, 32'h8, 32'd0);
        wait_done();
        @(negedge clk);
        n = cyc;
        for (int r = 0; r < 2; r++) begin
            model_core(1'b0, 2'b10, 1'b0, 32'h100, 64'd0, lat, rd, err);
            qc.push_back('{n + 6*r + 2, rd, err});
            model_dbg(1'b0, 32'h8, 32'd0, w);
            qd.push_back('{n + 6*r + 5, {32'd0, w}, 1'b0});
        end
        core_we = 1'b0; core_size = 2'b10; core_unsigned = 1'b0; core_addr = 32'h100;
        dbg_we = 1'b0; dbg_addr = 32'h8;
        core_req = 1'b1; dbg_req = 1'b1;
        nc = 0; nd = 0; nord = 0; ord = 4'd0;
        for (int k = 0; k < 40 && (core_req || dbg_req); k++) begin
            @(negedge clk);
            if (core_ack) begin ord = {ord[2:0], 1'b0}; nord++; nc++; if (nc == 2) core_req = 1'b0; end
            if (dbg_ack)  begin ord = {ord[2:0], 1'b1}; nord++; nd++; if (nd == 2) dbg_req = 1'b0; end
        end
        core_req = 1'b0; dbg_req = 1'b0;
        m_last_dbg = 1'b1;
        check_eq("rr_ack_count", 64'(nord), 64'd4);
        check_eq("rr_order", 64'(ord), 64'b0101);

        // LH 0x101: trapped or force-aligned depending on build.
        start_xact(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h101, 64'd0, 1'b0, 32'd0, 32'd0);
        n = x_start;
        @(negedge clk);
        check_eq("lh_mis_ram_we", 64'(ram_we), 64'd0);
        wait_done();
`ifdef DMEM_ALIGN_CHECK_EN
        check_eq("lh_mis_err", 64'(last_c_err), 64'd1);
        check_eq("lh_mis_latency", 64'(last_c_cyc - n), 64'd1);
        check_eq("lh_mis_rdata", last_c_rd, 64'd0);
`else
        check_eq("lh_mis_err", 64'(last_c_err), 64'd0);
        check_eq("lh_mis_latency", 64'(last_c_cyc - n), 64'd2);
        check_eq("lh_mis_rdata", last_c_rd, 64'h3456);
`endif

        // Reset during B1 of SD to 0x010: only the low word lands.
        old5 = ram[5];
        @(negedge clk);
        core_we = 1'b1; core_size = 2'b11; core_addr = 32'h10; core_wdata = 64'hCAFEF00D05060708;
        core_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_b1_addr", 64'(ram_addr), 64'd5);
        rst_n = 1'b0;
        core_req = 1'b0;
        #1;
        check_eq("abort_ram_we", 64'(ram_we), 64'd0);
        check_eq("abort_core_ack", 64'(core_ack), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("abort_no_ack", {62'd0, core_ack, dbg_ack}, 64'd0);
        end
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) ref_mem[16 + b] = core_wdata[8*b +: 8];
        m_last_dbg = 1'b1;
        check_eq("abort_ram4", 64'(ram[4]), 64'h05060708);
        check_eq("abort_ram5", 64'(ram[5]), 64'(old5));
        start_xact(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 64'd0, 1'b0, 32'd0, 32'd0);
        n = x_start;
        wait_done();
        check_eq("abort_ld_latency", 64'(last_c_cyc - n), 64'd3);
        check_eq("abort_ld_data", last_c_rd, {old5, 32'h05060708});

        // Randomized mix; half of the addresses fall in a small shared window.
        for (int it = 0; it < 300; it++) begin
            n = int'($urandom_range(0, 2));
            ce = (n != 1);
            de = (n != 0);
            caddr = $urandom;
            if ($urandom_range(0, 1) == 1) caddr[13:5] = 9'd0;
            daddr = $urandom;
            if ($urandom_range(0, 1) == 1) daddr[13:5] = 9'd0;
            start_xact(ce, de, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), caddr, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), daddr, $urandom);
            wait_done();
        end

        repeat (4) @(negedge clk);
        check_eq("pending_expectations", 64'(qc.size() + qd.size()), 64'd0);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]};
            if (ram[i] !== w) nbad++;
        end
        check_eq("ram_image_bad_words", 64'(nbad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the core LSU, the debug/loader port and the 32-bit byte-write data RAM. Arbitrates the two requesters round-robin and converts RV64I byte/half/word/double accesses into 32-bit RAM beats with byte-lane write enables. Loads are lane-extracted and sign- or zero-extended to 64 bits. Sits in MemoryAccess, directly in front of the RAM instance.

## Interface
- RAM_AW, 12, RAM word-address width; RAM depth is 2^RAM_AW 32-bit words.
- clk  in  1  global clock; all state updates on rising edge.
- rst_n  in  1  global reset, asynchronous, active-low.
- core_req  in  1  core access request; held high until core_ack.
- core_we  in  1  1 = store, 0 = load.
- core_size  in  2  00 byte, 01 half, 10 word, 11 double.
- core_unsigned  in  1  load zero-extend (LBU/LHU/LWU); ignored for stores and doubles.
- core_addr  in  32  byte address.
- core_wdata  in  64  store data, right-aligned.
- core_ack  out  1  one-cycle completion pulse.
- core_err  out  1  misaligned access; valid only with core_ack.
- core_rdata  out  64  load result; valid only with core_ack, 0 otherwise.
- dbg_req / dbg_we  in  1  debug word request / write; same hold rule as core.
- dbg_addr  in  32  byte address; bits [1:0] ignored.
- dbg_wdata  in  32  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  read word; valid only with dbg_ack, 0 otherwise.
- ram_addr  out  RAM_AW  RAM word address.
- ram_we  out  4  per-byte write enable, bit i = bits [8i+7:8i].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; registered, valid one cycle after ram_addr.

## Operation
- FSM states: IDLE, B0, B1, RESP, ERR.
- IDLE: sample requests; grant one and latch its request. Go to ERR if misaligned, else B0.
- B0: drive first-beat address and enables. Next is B1 if double, else RESP.
- B1: drive address+1 (wraps mod 2^RAM_AW) with the high word; capture ram_rdata (low word). Next is RESP.
- RESP: ack the granted port and form rdata from ram_rdata (plus captured low word). Next is IDLE.
- ERR: core_ack=1, core_err=1, core_rdata=0, no RAM access. Next is IDLE.
- Arbitration:
  - Round-robin.
  - On simultaneous requests, the port not granted last wins.
  - last_grant resets to dbg, so core wins the first tie.
  - A lone request is granted immediately.
- ram_addr = addr[RAM_AW+1:2]; upper address bits ignored (aliasing).
- Store lanes, off = addr[1:0]:
  - Byte: ram_we = 0001<<off, wdata = byte replicated x4.
  - Half: ram_we = 0011<<off, wdata = half replicated x2.
  - Word/double: ram_we = 1111.
  - Double: low word in B0, high word in B1.
- Load: select lane by off; sign-extend from bit 7/15/31 unless core_unsigned; double = {beat1, beat0}.
- Alignment rule: half needs addr[0]=0; word needs [1:0]=0; double needs [2:0]=0. dbg is always aligned.
- ram_we nonzero only in B0/B1 of a store; 0 in every other state.

## Timing
- Reset values: state IDLE, last_grant=dbg; all acks, core_err, ram_we, ram_addr, ram_wdata = 0; rdata outputs 0.
- Request granted in IDLE at cycle N:
  - ack at N+2 for byte/half/word and all dbg accesses.
  - ack at N+3 for double.
  - ack+err at N+1 for misaligned.
- Back-to-back: the next grant is no earlier than the cycle after ack.
- Request dropped before ack is a protocol violation; the latched transaction still completes and acks.
- Reset asserted mid-transaction: immediate abort, no ack, ram_we 0 asynchronously.
  - A double store aborted in B1 leaves only the low word written.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: misaligned core accesses take ERR as above.
- Undefined: no alignment check; core_err tied 0.
  - Misaligned addresses are forced down to natural alignment (low bits cleared) and the access proceeds normally.

## Test plan
- SB 0xA5 to 0x103 → at N+1: ram_addr=0x040, ram_we=1000, ram_wdata=0xA5A5A5A5; core_ack at N+2.
- RAM[0x040]=0x80123456; LB 0x103 → 0xFFFFFFFFFFFFFF80. LBU → 0x80. LH 0x102 → 0xFFFFFFFFFFFF8012.
- SD 0x1122334455667788 to 0x008:
  - Beat addr 2 / 0x55667788, then addr 3 / 0x11223344, ack at N+3.
  - LD 0x008 returns 0x1122334455667788.
- core_req and dbg_req held continuously → grants alternate core, dbg, core, dbg; each ack a single pulse.
- LH 0x101:
  - With macro: ack+err at N+1, ram_we stays 0000.
  - Without macro: data of 0x100 returned, err=0.
- rst_n low during B1 of SD to 0x010 → no ack, RAM[4] written, RAM[5] unchanged, FSM IDLE after release.
